tlb_array: RTL
==============

Name: tlb_array

Overview:
- 16-entry fully-associative MIPS-style joint TLB. It is the responder for the write-back stage's TLB write port (tlbwi) and read port (tlbr).
- Also serves two registered search ports: port 0 for instruction fetch, port 1 for data access and tlbp.
- Holds all entry state. CP0 and the pipeline stages only issue requests and consume the results.

Parameters:
- TLBNUM, 16, number of entries; must be a power of 2.
- IDX_W, 4, index width; equals log2(TLBNUM).

Ports:
- clk  in  1  clock
- resetn  in  1  async active-low reset
- s0_req  in  1  search request, port 0 (fetch)
- s0_vpn2  in  19  VA[31:13] for port 0
- s0_odd_page  in  1  VA[12] for port 0
- s0_asid  in  8  current ASID for port 0
- s0_resp_valid  out  1  port 0 result valid
- s0_found  out  1  port 0 hit
- s0_index  out  IDX_W  port 0 matching entry
- s0_pfn  out  20  port 0 selected-page PFN
- s0_c  out  3  port 0 selected-page cache attribute
- s0_d  out  1  port 0 selected-page dirty bit
- s0_v  out  1  port 0 selected-page valid bit
- s1_req, s1_vpn2, s1_odd_page, s1_asid  in  1/19/1/8  search request, port 1 (data/tlbp); same meanings as port 0
- s1_resp_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v  out  1/1/IDX_W/20/3/1/1  port 1 results; same meanings as port 0
- we  in  1  write enable (tlbwi)
- w_index  in  IDX_W  entry to write
- w_vpn2  in  19  write data: VPN2
- w_asid  in  8  write data: ASID
- w_g  in  1  write data: global bit
- w_pfn0, w_c0, w_d0, w_v0  in  20/3/1/1  write data: even page
- w_pfn1, w_c1, w_d1, w_v1  in  20/3/1/1  write data: odd page
- r_index  in  IDX_W  read index (tlbr)
- r_vpn2, r_asid, r_g  out  19/8/1  read data: entry tag fields
- r_pfn0, r_c0, r_d0, r_v0  out  20/3/1/1  read data: even page
- r_pfn1, r_c1, r_d1, r_v1  out  20/3/1/1  read data: odd page

Behaviour:
- Reset (resetn low, asynchronous):
  - Every field of every entry clears to 0.
  - All s*_resp_valid, s*_found, s*_index, s*_pfn, s*_c, s*_d, s*_v clear to 0.
  - Reset mid-search drops the pending response; no resp_valid follows deassertion.
- Match rule, entry i:
  - (vpn2[i] == s_vpn2) && (g[i] || asid[i] == s_asid).
  - Page select: odd_page = 0 selects the pfn0/c0/d0/v0 fields; odd_page = 1 selects the pfn1/c1/d1/v1 fields.
- Search latency is 1 cycle:
  - s*_req sampled high at edge N → s*_resp_valid high during cycle N+1 for exactly one cycle.
  - No backpressure; a new request is accepted every cycle.
  - Ports 0 and 1 are fully independent and may target the same entry simultaneously.
- Hold: s*_found, s*_index and the page fields keep their last values until the next accepted request on that port. Consumers may sample them after resp_valid drops.
- Miss: found = 0, index = 0, page fields = 0.
- Multiple hits (software error): the lowest-numbered matching entry wins, deterministically.
- Write: we high at edge N updates entry w_index at that edge. Out-of-range indices cannot occur because TLBNUM is a power of 2.
- Write and search in the same cycle: the search compares pre-write contents. A search issued in cycle N+1 sees the new entry.
- Read port: purely combinational from r_index over current entry state. A write at edge N is visible on r_* from cycle N+1. Same-cycle write to r_index returns the old contents.
- Requests issued while we is high for an unrelated index: unaffected.

Optional Feature:
- Macro TLB_MULTIHIT_EN.
- Defined:
  - Adds outputs s0_multi and s1_multi (1 bit each), registered alongside found.
  - sN_multi is high when two or more entries match on that port.
  - Reset value 0; held like found.
  - Selection remains lowest-index.
- Undefined: the ports are absent and there is no per-entry match-count logic.

Test Plan:
- Reset, then search s0 vpn2=0x12345, asid=0x01 → at N+1: resp_valid=1, found=0, index=0, pfn=0.
- Write idx 3 (vpn2=0x12345, asid=0x01, g=0, pfn0=0xAAAAA, v0=1, pfn1=0xBBBBB, d1=1, v1=1); then s1 search with odd=1, asid=0x01 → found=1, index=3, pfn=0xBBBBB, d=1, v=1. The same search with asid=0x02 → found=0.
- Write idx 7 with g=1; search with any asid → found=1, index=7. Then r_index=7 → r_g=1 and all r_* fields match the written data.
- Same-cycle we to idx 5 and s0_req for the new vpn2 → found=0. A repeat request one cycle later → found=1, index=5.
- Back-to-back s0 requests on 3 consecutive cycles, alternating hit/miss, while port 1 idles → resp_valid high 3 consecutive cycles with correct per-cycle results. s1_resp_valid stays 0 and port 1 outputs hold.
- Identical vpn2/asid written to idx 2 and idx 9, then searched → index=2. With TLB_MULTIHIT_EN defined, multi=1.

Source files
------------

// File: rtl/tlb_array.sv
// 16-entry fully-associative joint TLB with two registered search ports, a tlbwi write port and a combinational tlbr read port.
// Define TLB_MULTIHIT_EN to add the s0_multi/s1_multi multiple-match flags.
module tlb_array #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s0_req,
  input  logic [18:0]      s0_vpn2,
  input  logic             s0_odd_page,
  input  logic [7:0]       s0_asid,
  output logic             s0_resp_valid,
  output logic             s0_found,
  output logic [IDX_W-1:0] s0_index,
  output logic [19:0]      s0_pfn,
  output logic [2:0]       s0_c,
  output logic             s0_d,
  output logic             s0_v,
  input  logic             s1_req,
  input  logic [18:0]      s1_vpn2,
  input  logic             s1_odd_page,
  input  logic [7:0]       s1_asid,
  output logic             s1_resp_valid,
  output logic             s1_found,
  output logic [IDX_W-1:0] s1_index,
  output logic [19:0]      s1_pfn,
  output logic [2:0]       s1_c,
  output logic             s1_d,
  output logic             s1_v,
`ifdef TLB_MULTIHIT_EN
  output logic             s0_multi,
  output logic             s1_multi,
`endif
  input  logic             we,
  input  logic [IDX_W-1:0] w_index,
  input  logic [18:0]      w_vpn2,
  input  logic [7:0]       w_asid,
  input  logic             w_g,
  input  logic [19:0]      w_pfn0,
  input  logic [2:0]       w_c0,
  input  logic             w_d0,
  input  logic             w_v0,
  input  logic [19:0]      w_pfn1,
  input  logic [2:0]       w_c1,
  input  logic             w_d1,
  input  logic             w_v1,
  input  logic [IDX_W-1:0] r_index,
  output logic [18:0]      r_vpn2,
  output logic [7:0]       r_asid,
  output logic             r_g,
  output logic [19:0]      r_pfn0,
  output logic [2:0]       r_c0,
  output logic             r_d0,
  output logic             r_v0,
  output logic [19:0]      r_pfn1,
  output logic [2:0]       r_c1,
  output logic             r_d1,
  output logic             r_v1
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } entry_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
    logic [19:0]      pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
  } resp_t;

  entry_t              tlb_q [TLBNUM];
  entry_t              w_entry;
  entry_t              rd_entry;
  logic [TLBNUM-1:0]   hit0;
  logic [TLBNUM-1:0]   hit1;
  logic [IDX_W-1:0]    idx0;
  logic [IDX_W-1:0]    idx1;
  resp_t               nxt0;
  resp_t               nxt1;
  resp_t               rsp0_p1;
  resp_t               rsp1_p1;
  logic                vld0_p1;
  logic                vld1_p1;

  function automatic logic entry_match(entry_t e, logic [18:0] vpn2, logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  // Scanning downward leaves the lowest matching index, so duplicate entries resolve deterministically.
  function automatic logic [IDX_W-1:0] first_hit(logic [TLBNUM-1:0] hits);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hits[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic resp_t page_sel(logic hit, logic [IDX_W-1:0] idx, entry_t e, logic odd);
    resp_t r;
    r = '0;
    if (hit) begin
      r.found = 1'b1;
      r.index = idx;
      if (odd) begin
        r.pfn = e.pfn1;
        r.c   = e.c1;
        r.d   = e.d1;
        r.v   = e.v1;
      end else begin
        r.pfn = e.pfn0;
        r.c   = e.c0;
        r.d   = e.d0;
        r.v   = e.v0;
      end
    end
    return r;
  endfunction

`ifdef TLB_MULTIHIT_EN
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_hit(logic [TLBNUM-1:0] hits);
    return |(hits & (hits - TLBNUM'(1)));
  endfunction
`endif

  assign w_entry = {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1};

  always_comb begin
    hit0 = '0;
    hit1 = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      hit0[i] = entry_match(tlb_q[i], s0_vpn2, s0_asid);
      hit1[i] = entry_match(tlb_q[i], s1_vpn2, s1_asid);
    end
    idx0 = first_hit(hit0);
    idx1 = first_hit(hit1);
    nxt0 = page_sel(|hit0, idx0, tlb_q[idx0], s0_odd_page);
    nxt1 = page_sel(|hit1, idx1, tlb_q[idx1], s1_odd_page);
  end

  // Entry storage: searches in the write cycle still see the old contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= '0;
    end else if (we) begin
      tlb_q[w_index] <= w_entry;
    end
  end

  // Stage p1: search results, held until the next accepted request on the port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld0_p1 <= 1'b0;
      vld1_p1 <= 1'b0;
      rsp0_p1 <= '0;
      rsp1_p1 <= '0;
    end else begin
      vld0_p1 <= s0_req;
      vld1_p1 <= s1_req;
      if (s0_req) rsp0_p1 <= nxt0;
      if (s1_req) rsp1_p1 <= nxt1;
    end
  end

`ifdef TLB_MULTIHIT_EN
  logic multi0_p1;
  logic multi1_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      multi0_p1 <= 1'b0;
      multi1_p1 <= 1'b0;
    end else begin
      if (s0_req) multi0_p1 <= multi_hit(hit0);
      if (s1_req) multi1_p1 <= multi_hit(hit1);
    end
  end

  assign s0_multi = multi0_p1;
  assign s1_multi = multi1_p1;
`endif

  assign s0_resp_valid = vld0_p1;
  assign s0_found      = rsp0_p1.found;
  assign s0_index      = rsp0_p1.index;
  assign s0_pfn        = rsp0_p1.pfn;
  assign s0_c          = rsp0_p1.c;
  assign s0_d          = rsp0_p1.d;
  assign s0_v          = rsp0_p1.v;

  assign s1_resp_valid = vld1_p1;
  assign s1_found      = rsp1_p1.found;
  assign s1_index      = rsp1_p1.index;
  assign s1_pfn        = rsp1_p1.pfn;
  assign s1_c          = rsp1_p1.c;
  assign s1_d          = rsp1_p1.d;
  assign s1_v          = rsp1_p1.v;

  assign rd_entry = tlb_q[r_index];
  assign r_vpn2   = rd_entry.vpn2;
  assign r_asid   = rd_entry.asid;
  assign r_g      = rd_entry.g;
  assign r_pfn0   = rd_entry.pfn0;
  assign r_c0     = rd_entry.c0;
  assign r_d0     = rd_entry.d0;
  assign r_v0     = rd_entry.v0;
  assign r_pfn1   = rd_entry.pfn1;
  assign r_c1     = rd_entry.c1;
  assign r_d1     = rd_entry.d1;
  assign r_v1     = rd_entry.v1;

endmodule
